// File: rtl/casez_chk_pkg.sv
// casez_chk_pkg: shared state type, vector count and check masks for the
// casez stimulus checker and its expected-response model.
package casez_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 16;

  // Bit p set means the output is checked for LSB triple p.
  localparam logic [7:0] OUT3_MASK = 8'b0000_0011;
  localparam logic [7:0] OUT5_MASK = 8'b0001_0110;

  // Priority code of {a,b,c}: the highest set bit wins, 3 when none is set.
  function automatic logic [1:0] prioCode(input logic [2:0] p);
    if (p[2]) begin
      return 2'd0;
    end else if (p[1]) begin
      return 2'd1;
    end else if (p[0]) begin
      return 2'd2;
    end
    return 2'd3;
  endfunction

endpackage

// File: rtl/casez_stim_checker_if.sv
// casez_stim_checker_if: stimulus and response buses between the checker
// (master) and the casez decode block (slave).
interface casez_stim_checker_if #(parameter int SIZE = 1);

  logic [SIZE-1:0] src1;
  logic [SIZE-1:0] src2;
  logic [SIZE-1:0] src3;
  logic [SIZE-1:0] out1;
  logic [SIZE-1:0] out2;
  logic [SIZE-1:0] out3;
  logic [SIZE-1:0] out4;
  logic [SIZE-1:0] out5;

  modport master (
    output src1, src2, src3,
    input  out1, out2, out3, out4, out5
  );

  modport slave (
    input  src1, src2, src3,
    output out1, out2, out3, out4, out5
  );

endinterface

// File: rtl/casez_expect_model.sv
// casez_expect_model: golden responses of the casez decode block for one LSB
// triple p, truncated to SIZE bits, plus which outputs are meaningful for p.
module casez_expect_model
  import casez_chk_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic [2:0]      i_p,
  output logic [SIZE-1:0] o_exp1,
  output logic [SIZE-1:0] o_exp2,
  output logic [SIZE-1:0] o_exp3,
  output logic [SIZE-1:0] o_exp4,
  output logic [SIZE-1:0] o_exp5,
  output logic [4:0]      o_chkEn
);

  // Expected values per output; out3/out5 only carry meaning at masked p
  always_comb begin
    o_exp1  = SIZE'(i_p);
    o_exp2  = SIZE'(prioCode(i_p));
    o_exp4  = SIZE'(prioCode(i_p));
    o_exp3  = '0;
    o_exp5  = '0;
    case (i_p)
      3'b000: o_exp3 = SIZE'(3);
      3'b001: begin
        o_exp3 = SIZE'(2);
        o_exp5 = SIZE'(1);
      end
      3'b010: o_exp5 = SIZE'(2);
      3'b100: o_exp5 = SIZE'(3);
      default: ;
    endcase
    o_chkEn = {OUT5_MASK[i_p], 1'b1, OUT3_MASK[i_p], 1'b1, 1'b1};
  end

endmodule

// File: rtl/casez_stim_checker.sv
// casez_stim_checker: walks the three source buses through all 16 vectors
// (8 LSB triples x 2 upper-bit fills), compares the decoder responses one
// cycle after each vector and keeps a mismatch count and first failing vector.
module casez_stim_checker
  import casez_chk_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic [4:0] o_errCount,
  output logic       o_failValid,
  output logic [3:0] o_failIndex,
  casez_stim_checker_if.master bus
);

  localparam logic [SIZE-1:0] LSB_ONE = SIZE'(1);

  state_t          r_state;
  state_t          w_nextState;
  logic [3:0]      r_vec;
  logic [4:0]      r_errCount;
  logic            r_failValid;
  logic [3:0]      r_failIndex;

  logic [2:0]      w_p;
  logic [SIZE-1:0] w_fill;
  logic            w_active;
  logic            w_lastVec;
  logic            w_mismatch;
  logic [SIZE-1:0] w_exp1;
  logic [SIZE-1:0] w_exp2;
  logic [SIZE-1:0] w_exp3;
  logic [SIZE-1:0] w_exp4;
  logic [SIZE-1:0] w_exp5;
  logic [4:0]      w_chkEn;

  assign w_p       = r_vec[2:0];
  assign w_fill    = {SIZE{r_vec[3]}};
  assign w_active  = (r_state == DRIVE) || (r_state == SAMPLE);
  assign w_lastVec = (r_vec == 4'(NUM_VEC - 1));

  casez_expect_model #(.SIZE(SIZE)) u_expect (
    .i_p     (w_p),
    .o_exp1  (w_exp1),
    .o_exp2  (w_exp2),
    .o_exp3  (w_exp3),
    .o_exp4  (w_exp4),
    .o_exp5  (w_exp5),
    .o_chkEn (w_chkEn)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus busy/done decode; start only counts in IDLE
  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = DRIVE;
        end
      end
      DRIVE: begin
        o_busy      = 1'b1;
        w_nextState = SAMPLE;
      end
      SAMPLE: begin
        o_busy      = 1'b1;
        w_nextState = w_lastVec ? DONE : DRIVE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Sources present the current vector while active and sit at zero otherwise
  always_comb begin
    bus.src1 = '0;
    bus.src2 = '0;
    bus.src3 = '0;
    if (w_active) begin
      bus.src1 = (w_fill & ~LSB_ONE) | (w_p[2] ? LSB_ONE : '0);
      bus.src2 = (w_fill & ~LSB_ONE) | (w_p[1] ? LSB_ONE : '0);
      bus.src3 = (w_fill & ~LSB_ONE) | (w_p[0] ? LSB_ONE : '0);
    end
  end

  // Any enabled output differing from the model (X/Z included) is a mismatch
  always_comb begin
    w_mismatch = 1'b0;
    if (w_chkEn[0] && (bus.out1 !== w_exp1)) w_mismatch = 1'b1;
    if (w_chkEn[1] && (bus.out2 !== w_exp2)) w_mismatch = 1'b1;
    if (w_chkEn[2] && (bus.out3 !== w_exp3)) w_mismatch = 1'b1;
    if (w_chkEn[3] && (bus.out4 !== w_exp4)) w_mismatch = 1'b1;
    if (w_chkEn[4] && (bus.out5 !== w_exp5)) w_mismatch = 1'b1;
  end

  // Results clear on an accepted start and accumulate in each SAMPLE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec       <= '0;
      r_errCount  <= '0;
      r_failValid <= 1'b0;
      r_failIndex <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_vec       <= '0;
            r_errCount  <= '0;
            r_failValid <= 1'b0;
            r_failIndex <= '0;
          end
        end
        SAMPLE: begin
          if (w_mismatch) begin
            r_errCount <= r_errCount + 5'd1;
            if (!r_failValid) begin
              r_failValid <= 1'b1;
              r_failIndex <= r_vec;
            end
          end
          if (!w_lastVec) begin
            r_vec <= r_vec + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_errCount  = r_errCount;
  assign o_failValid = r_failValid;
  assign o_failIndex = r_failIndex;

endmodule

// File: tb/tb_casez_stim_checker.sv
// tb_casez_stim_checker: drives the checker against a behavioural casez decoder
// with selectable faults; run results go through a scoreboard retired on done.
module tb_casez_stim_checker;

  localparam int TB_SIZE = 3;

  typedef struct packed {
    logic [4:0] errCount;
    logic       failValid;
    logic [3:0] failIndex;
  } result_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         busy;
  logic         done;
  logic [4:0]   errCount;
  logic         failValid;
  logic [3:0]   failIndex;
  logic [2:0]   decP;
  int           faultMode;
  int           checks = 0;
  int           errors = 0;
  result_t      sbQueue[$];
  result_t      sbExp;

  casez_stim_checker_if #(.SIZE(TB_SIZE)) bus ();

  casez_stim_checker #(.SIZE(TB_SIZE)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_errCount  (errCount),
    .o_failValid (failValid),
    .o_failIndex (failIndex),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Decode block stand-in: 1 = out2 stuck at 0, 2 = out5 is 3 at p=010,
  // 3 = out3 is 5 at p=110; unchecked positions carry deliberate noise
  always_comb begin
    decP     = {bus.src1[0], bus.src2[0], bus.src3[0]};
    bus.out1 = TB_SIZE'(decP);
    casez (decP)
      3'b1??:  bus.out2 = TB_SIZE'(0);
      3'b01?:  bus.out2 = TB_SIZE'(1);
      3'b001:  bus.out2 = TB_SIZE'(2);
      default: bus.out2 = TB_SIZE'(3);
    endcase
    bus.out4 = bus.out2;
    if (faultMode == 1) bus.out2 = '0;
    case (decP)
      3'b001:  bus.out3 = TB_SIZE'(2);
      3'b000:  bus.out3 = TB_SIZE'(3);
      default: bus.out3 = TB_SIZE'(7);
    endcase
    if (faultMode == 3 && decP == 3'b110) bus.out3 = TB_SIZE'(5);
    case (decP)
      3'b001:  bus.out5 = TB_SIZE'(1);
      3'b010:  bus.out5 = TB_SIZE'(2);
      3'b100:  bus.out5 = TB_SIZE'(3);
      default: bus.out5 = TB_SIZE'(6);
    endcase
    if (faultMode == 2 && decP == 3'b010) bus.out5 = TB_SIZE'(3);
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Source value for vector v: upper bits follow the pass, bit 0 the triple bit
  function automatic logic [TB_SIZE-1:0] expSrc(input int v, input int which);
    logic [TB_SIZE-1:0] s;
    logic [3:0]         vb;
    vb   = 4'(v);
    s    = vb[3] ? '1 : '0;
    s[0] = vb[2 - which];
    return s;
  endfunction

  // Scoreboard: each done pulse retires the oldest expected run result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedDone", 32'(done), 32'(0));
      end else begin
        sbExp = sbQueue.pop_front();
        checkOutput("sbErrCount", 32'(errCount), 32'(sbExp.errCount));
        checkOutput("sbFailValid", 32'(failValid), 32'(sbExp.failValid));
        checkOutput("sbFailIndex", 32'(failIndex), 32'(sbExp.failIndex));
      end
    end
  end

  // One full run from a negedge in IDLE; optionally pokes start while busy/DONE
  task automatic applyStimulus(input int mode, input logic [4:0] expErr,
                               input logic expValid, input logic [3:0] expIdx,
                               input bit pokeStart);
    result_t expRes;
    faultMode          = mode;
    expRes.errCount    = expErr;
    expRes.failValid   = expValid;
    expRes.failIndex   = expIdx;
    sbQueue.push_back(expRes);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int v = 0; v < 16; v++) begin
      for (int ph = 0; ph < 2; ph++) begin
        checkOutput("runBusy", 32'(busy), 32'(1));
        checkOutput("runDone", 32'(done), 32'(0));
        checkOutput("src1", 32'(bus.src1), 32'(expSrc(v, 0)));
        checkOutput("src2", 32'(bus.src2), 32'(expSrc(v, 1)));
        checkOutput("src3", 32'(bus.src3), 32'(expSrc(v, 2)));
        start = (pokeStart && v == 5 && ph == 0);
        @(negedge clk);
      end
    end
    checkOutput("doneCycleBusy", 32'(busy), 32'(0));
    checkOutput("doneCycleDone", 32'(done), 32'(1));
    checkOutput("doneCycleSrc1", 32'(bus.src1), 32'(0));
    start = pokeStart;
    @(negedge clk);
    start = 1'b0;
    checkOutput("idleBusy", 32'(busy), 32'(0));
    checkOutput("idleDone", 32'(done), 32'(0));
    checkOutput("holdErrCount", 32'(errCount), 32'(expErr));
    checkOutput("holdFailValid", 32'(failValid), 32'(expValid));
    checkOutput("holdFailIndex", 32'(failIndex), 32'(expIdx));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    faultMode = 0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    checkOutput("rstSrc1", 32'(bus.src1), 32'(0));
    checkOutput("rstErrCount", 32'(errCount), 32'(0));
    checkOutput("rstFailValid", 32'(failValid), 32'(0));
    checkOutput("rstFailIndex", 32'(failIndex), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterRstBusy", 32'(busy), 32'(0));

    // Golden decoder: noise only at unchecked positions
    applyStimulus(0, 5'd0, 1'b0, 4'd0, 1'b0);
    // out2 stuck at 0: p=000..011 in both passes mismatch, first at v=0
    applyStimulus(1, 5'd8, 1'b1, 4'd0, 1'b1);
    // out5 wrong at p=010: v=2 and v=10
    applyStimulus(2, 5'd2, 1'b1, 4'b0010, 1'b0);
    // disturbance on out3 at an unchecked triple
    applyStimulus(3, 5'd0, 1'b0, 4'd0, 1'b0);

    // Reset partway through a faulty run
    faultMode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("preResetErrCount", 32'(errCount), 32'(4));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(busy), 32'(0));
    checkOutput("midRstDone", 32'(done), 32'(0));
    checkOutput("midRstSrc1", 32'(bus.src1), 32'(0));
    checkOutput("midRstSrc2", 32'(bus.src2), 32'(0));
    checkOutput("midRstSrc3", 32'(bus.src3), 32'(0));
    checkOutput("midRstErrCount", 32'(errCount), 32'(0));
    checkOutput("midRstFailValid", 32'(failValid), 32'(0));
    checkOutput("midRstFailIndex", 32'(failIndex), 32'(0));
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      checkOutput("postRstNoDone", 32'(done), 32'(0));
      checkOutput("postRstBusy", 32'(busy), 32'(0));
    end
    applyStimulus(0, 5'd0, 1'b0, 4'd0, 1'b0);

    // start held high: back-to-back runs, done every 34 cycles
    faultMode = 0;
    sbQueue.push_back('{errCount: 5'd0, failValid: 1'b0, failIndex: 4'd0});
    sbQueue.push_back('{errCount: 5'd0, failValid: 1'b0, failIndex: 4'd0});
    start = 1'b1;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      checkOutput("heldDone", 32'(done), 32'((c == 33) || (c == 67)));
      checkOutput("heldBusy", 32'(busy),
                  32'(!((c == 33) || (c == 34) || (c == 67) || (c == 68))));
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("afterHeldBusy", 32'(busy), 32'(0));
    end

    checkOutput("sbEmpty", 32'(sbQueue.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
